cp0_intr_ctrl: RTL and testbench
================================

Name: cp0_intr_ctrl

Overview:
Consumer-side companion to the CP0 Status/Cause write logic. It reads Status IE/EXL/IM and Cause software IP bits, and owns four things:
- synchronisation of the six hardware interrupt lines;
- the Count/Compare timer and its TI flag;
- the mfc0 read path for Count, Compare and Cause.
- the interrupt request handshake to the exception unit in the pipeline.

Parameters:
ADDR_COUNT, 7'h24, cp0_addr encoding {reg[4:0],sel[1:0]} for Count (reg 9, sel 0)
ADDR_COMPARE, 7'h2C, encoding for Compare (reg 11, sel 0)
ADDR_CAUSE, 7'h34, encoding for Cause (reg 13, sel 0)
COMPARE_INI, 32'hFFFF_FFFF, Compare reset value

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  reset, asynchronous, active-high
ext_int_in  in  6  asynchronous hardware interrupt lines HW0..HW5
status_ie  in  1  Status.IE
status_exl  in  1  Status.EXL
status_im  in  8  Status.IM[7:0]
cause_ip_sw  in  2  Cause.IP[1:0] (software interrupts)
eret_flush  in  1  eret retiring this cycle
mtc0_we  in  1  mtc0 write strobe
cp0_addr  in  7  mtc0 target address
mtc0_data  in  32  mtc0 write data
mfc0_re  in  1  mfc0 read strobe
mfc0_addr  in  7  mfc0 source address
mfc0_data  out  32  read data, registered
mfc0_valid  out  1  read data valid, one-cycle pulse
cause_ip_hw  out  6  Cause.IP[7:2] as seen by the core
cause_ti  out  1  Cause.TI
int_req  out  1  interrupt request to exception unit
int_ack  in  1  exception unit has taken the interrupt

Behaviour:
Reset values:
- All outputs are 0.
- Count is 0, Compare is COMPARE_INI, tick is 0, synchroniser flops are 0, FSM is IDLE.

Hardware interrupt path:
- Each ext_int_in bit passes through a 2-flop synchroniser.
- cause_ip_hw[4:0] = sync[4:0].
- cause_ip_hw[5] = sync[5] | cause_ti.
- Latency from pin to cause_ip_hw is 2 cycles, not latched.

Timer:
- tick toggles every cycle. Count increments (wraps FFFF_FFFF->0) on cycles where tick==1, i.e. every 2 clocks.
- mtc0 to ADDR_COUNT loads Count; the write beats a same-cycle increment.
- cause_ti sets on the cycle Count increments to a value equal to Compare.
- cause_ti clears on an mtc0 to ADDR_COMPARE, which also loads Compare. If a match and a Compare write coincide, the clear wins.
- cause_ti is sticky otherwise. A Count write never sets cause_ti.

Pending condition:
- pend = status_ie & ~status_exl & |({cause_ip_hw,cause_ip_sw} & status_im).

Interrupt FSM (int_req = state==REQ, registered):
- IDLE -> REQ when pend.
- REQ -> IDLE when ~pend and ~int_ack (interrupt withdrawn).
- REQ -> BLOCK when int_ack. int_ack takes priority over a same-cycle withdrawal.
- BLOCK -> IDLE on eret_flush.
- BLOCK -> IDLE also on status_exl==0 && ~pend for 1 cycle, as a safety exit.
- int_ack outside REQ is ignored.
- Reset in any state returns to IDLE immediately and drops int_req asynchronously.

mfc0 read:
- 1-cycle latency. A mfc0_re in cycle N gives mfc0_data/mfc0_valid in cycle N+1, with mfc0_valid high for exactly 1 cycle.
- Count returns the Count value before any same-cycle update.
- Compare returns the Compare value.
- Cause returns {1'b0, cause_ti, 14'b0, cause_ip_hw, cause_ip_sw, 8'b0}; other Cause fields read 0 and are merged by the Cause owner.
- An unknown address returns 0 with mfc0_valid still asserted.
- mfc0_data holds its last value when mfc0_re is low.
- Back-to-back reads are supported every cycle.

Test Plan:
- Reset then idle 20 cycles -> Count==10, cause_ti=0, int_req=0, mfc0 of ADDR_COUNT returns 32'd10 one cycle after mfc0_re.
- mtc0 Count=5, Compare=8 -> cause_ti rises on the increment to 8 (6 cycles later). With status_ie=1, exl=0, im[7]=1, int_req rises 1 cycle later. Writing Compare drops cause_ti next cycle.
- ext_int_in[2] pulses high and stays high, with ie=1, im[4]=1 -> cause_ip_hw[2] after 2 cycles, int_req 1 cycle later. int_ack -> BLOCK, int_req=0. eret_flush -> IDLE, then int_req re-asserts because the line is still high.
- int_req high, ext line drops before ack -> FSM returns to IDLE, int_req=0 next cycle. Simultaneous drop and int_ack -> BLOCK.
- Count=FFFF_FFFF, Compare=0 -> Count wraps to 0 and cause_ti sets. Same-cycle Compare write during the match -> cause_ti stays 0.
- Assert rst mid-REQ -> int_req=0 without waiting for a clock edge. Count=0, Compare=FFFF_FFFF after release.

Source files
------------

// File: rtl/cp0_intr_ctrl.sv
// cp0_intr_ctrl: CP0 interrupt consumer block.
// Synchronises the six hardware interrupt lines, runs the Count/Compare
// timer and its TI flag, serves mfc0 reads of Count/Compare/Cause, and
// raises the interrupt request towards the pipeline's exception unit.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   ext_int_in[5:0]     asynchronous hardware interrupt pins HW0..HW5
//   status_ie/exl/im    Status fields from the Status owner
//   cause_ip_sw[1:0]    software interrupt pending bits
//   eret_flush          eret retiring this cycle
//   mtc0_we/cp0_addr/mtc0_data   mtc0 write port (Count, Compare)
//   mfc0_re/mfc0_addr   mfc0 read request
//   mfc0_data/mfc0_valid  registered read response, one cycle later
//   cause_ip_hw[5:0]    Cause.IP[7:2]; bit 5 also carries the timer
//   cause_ti            Cause.TI
//   int_req/int_ack     interrupt request handshake
module cp0_intr_ctrl #(
    parameter logic [6:0]  ADDR_COUNT   = 7'h24,
    parameter logic [6:0]  ADDR_COMPARE = 7'h2C,
    parameter logic [6:0]  ADDR_CAUSE   = 7'h34,
    parameter logic [31:0] COMPARE_INI  = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  ext_int_in,
    input  logic        status_ie,
    input  logic        status_exl,
    input  logic [7:0]  status_im,
    input  logic [1:0]  cause_ip_sw,
    input  logic        eret_flush,
    input  logic        mtc0_we,
    input  logic [6:0]  cp0_addr,
    input  logic [31:0] mtc0_data,
    input  logic        mfc0_re,
    input  logic [6:0]  mfc0_addr,
    output logic [31:0] mfc0_data,
    output logic        mfc0_valid,
    output logic [5:0]  cause_ip_hw,
    output logic        cause_ti,
    output logic        int_req,
    input  logic        int_ack
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned HW_W   = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        BLOCK = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [HW_W-1:0]   sync_meta;
    logic [HW_W-1:0]   sync_out;
    logic              tick;
    logic [DATA_W-1:0] count;
    logic [DATA_W-1:0] compare;
    logic [DATA_W-1:0] count_inc_c;
    logic              count_we_c;
    logic              compare_we_c;
    logic              match_c;
    logic              pend_c;
    logic [DATA_W-1:0] rd_data_c;

    // Two-flop synchroniser for the hardware interrupt pins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta <= '0;
            sync_out  <= '0;
        end else begin
            sync_meta <= ext_int_in;
            sync_out  <= sync_meta;
        end
    end

    // Timer interrupt shares IP7 with HW5
    assign cause_ip_hw = {sync_out[HW_W-1] | cause_ti, sync_out[HW_W-2:0]};

    assign count_we_c   = mtc0_we && (cp0_addr == ADDR_COUNT);
    assign compare_we_c = mtc0_we && (cp0_addr == ADDR_COMPARE);
    assign count_inc_c  = count + DATA_W'(1);
    // Only a real increment can match; a software load of Count never fires TI
    assign match_c      = tick && !count_we_c && (count_inc_c == compare);

    // Count/Compare timer and sticky TI flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick     <= 1'b0;
            count    <= '0;
            compare  <= COMPARE_INI;
            cause_ti <= 1'b0;
        end else begin
            tick <= ~tick;
            if (count_we_c) begin
                count <= mtc0_data;
            end else if (tick) begin
                count <= count_inc_c;
            end
            if (compare_we_c) begin
                compare <= mtc0_data;
            end
            // Compare write acknowledges the timer, even against a fresh match
            if (compare_we_c) begin
                cause_ti <= 1'b0;
            end else if (match_c) begin
                cause_ti <= 1'b1;
            end
        end
    end

    assign pend_c = status_ie && !status_exl &&
                    (|({cause_ip_hw, cause_ip_sw} & status_im));

    // Interrupt request FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            int_req <= 1'b0;
        end else begin
            state   <= state_next;
            int_req <= (state_next == REQ);
        end
    end

    // Interrupt request FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (pend_c) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (int_ack) begin
                    state_next = BLOCK;
                end else if (!pend_c) begin
                    state_next = IDLE;
                end
            end
            BLOCK: begin
                // eret is the normal exit; EXL clear with nothing pending is a safety exit
                if (eret_flush || (!status_exl && !pend_c)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // mfc0 source select; Cause carries only the fields this block owns
    always_comb begin
        rd_data_c = '0;
        if (mfc0_addr == ADDR_COUNT) begin
            rd_data_c = count;
        end else if (mfc0_addr == ADDR_COMPARE) begin
            rd_data_c = compare;
        end else if (mfc0_addr == ADDR_CAUSE) begin
            rd_data_c = {1'b0, cause_ti, 14'b0, cause_ip_hw, cause_ip_sw, 8'b0};
        end
    end

    // Registered read response; data holds between reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mfc0_data  <= '0;
            mfc0_valid <= 1'b0;
        end else begin
            mfc0_valid <= mfc0_re;
            if (mfc0_re) begin
                mfc0_data <= rd_data_c;
            end
        end
    end

endmodule

// File: tb/tb_cp0_intr_ctrl.sv
// tb_cp0_intr_ctrl: self-checking bench for cp0_intr_ctrl.
// Directed scenarios plus a randomized run, all checked against a
// behavioural model of the CP0 interrupt rules kept in this file.
module tb_cp0_intr_ctrl;

    localparam logic [6:0] A_COUNT   = 7'h24;
    localparam logic [6:0] A_COMPARE = 7'h2C;
    localparam logic [6:0] A_CAUSE   = 7'h34;

    localparam int M_IDLE  = 0;
    localparam int M_REQ   = 1;
    localparam int M_BLOCK = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  ext_int_in;
    logic        status_ie;
    logic        status_exl;
    logic [7:0]  status_im;
    logic [1:0]  cause_ip_sw;
    logic        eret_flush;
    logic        mtc0_we;
    logic [6:0]  cp0_addr;
    logic [31:0] mtc0_data;
    logic        mfc0_re;
    logic [6:0]  mfc0_addr;
    logic [31:0] mfc0_data;
    logic        mfc0_valid;
    logic [5:0]  cause_ip_hw;
    logic        cause_ti;
    logic        int_req;
    logic        int_ack;

    int tests = 0;
    int fails = 0;

    cp0_intr_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .ext_int_in  (ext_int_in),
        .status_ie   (status_ie),
        .status_exl  (status_exl),
        .status_im   (status_im),
        .cause_ip_sw (cause_ip_sw),
        .eret_flush  (eret_flush),
        .mtc0_we     (mtc0_we),
        .cp0_addr    (cp0_addr),
        .mtc0_data   (mtc0_data),
        .mfc0_re     (mfc0_re),
        .mfc0_addr   (mfc0_addr),
        .mfc0_data   (mfc0_data),
        .mfc0_valid  (mfc0_valid),
        .cause_ip_hw (cause_ip_hw),
        .cause_ti    (cause_ti),
        .int_req     (int_req),
        .int_ack     (int_ack)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [31:0] m_count;
    logic [31:0] m_compare;
    logic        m_tick;
    logic        m_ti;
    logic [5:0]  m_pin_d1;
    logic [5:0]  m_pin_d2;
    int          m_st;
    logic [31:0] m_data;
    logic        m_valid;

    function automatic logic [5:0] f_ip();
        return {m_pin_d2[5] | m_ti, m_pin_d2[4:0]};
    endfunction

    function automatic logic f_pend();
        logic [7:0] lines;
        lines = {f_ip(), cause_ip_sw};
        return status_ie && !status_exl && ((lines & status_im) != 8'h00);
    endfunction

    function automatic logic [31:0] f_read(input logic [6:0] a);
        if (a == A_COUNT)   return m_count;
        if (a == A_COMPARE) return m_compare;
        if (a == A_CAUSE)   return {1'b0, m_ti, 14'b0, f_ip(), cause_ip_sw, 8'b0};
        return 32'h0;
    endfunction

    function automatic int f_next_st();
        logic p;
        p = f_pend();
        if (m_st == M_IDLE)  return p ? M_REQ : M_IDLE;
        if (m_st == M_REQ)   return int_ack ? M_BLOCK : (p ? M_REQ : M_IDLE);
        return (eret_flush || (!status_exl && !p)) ? M_IDLE : M_BLOCK;
    endfunction

    function automatic logic [31:0] f_next_count();
        if (mtc0_we && cp0_addr == A_COUNT) return mtc0_data;
        if (m_tick) return m_count + 32'd1;
        return m_count;
    endfunction

    function automatic logic f_next_ti();
        if (mtc0_we && cp0_addr == A_COMPARE) return 1'b0;
        if (m_tick && !(mtc0_we && cp0_addr == A_COUNT) && (m_count + 32'd1 == m_compare))
            return 1'b1;
        return m_ti;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_count   <= 32'd0;
            m_compare <= 32'hFFFF_FFFF;
            m_tick    <= 1'b0;
            m_ti      <= 1'b0;
            m_pin_d1  <= 6'd0;
            m_pin_d2  <= 6'd0;
            m_st      <= M_IDLE;
            m_data    <= 32'd0;
            m_valid   <= 1'b0;
        end else begin
            m_valid   <= mfc0_re;
            m_data    <= mfc0_re ? f_read(mfc0_addr) : m_data;
            m_st      <= f_next_st();
            m_count   <= f_next_count();
            m_compare <= (mtc0_we && cp0_addr == A_COMPARE) ? mtc0_data : m_compare;
            m_ti      <= f_next_ti();
            m_tick    <= ~m_tick;
            m_pin_d2  <= m_pin_d1;
            m_pin_d1  <= ext_int_in;
        end
    end

    function automatic logic [40:0] dut_vec();
        return {int_req, cause_ti, cause_ip_hw, mfc0_valid, mfc0_data};
    endfunction

    function automatic logic [40:0] mdl_vec();
        return {(m_st == M_REQ), m_ti, f_ip(), m_valid, m_data};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        mtc0_we    = 1'b0;
        mfc0_re    = 1'b0;
        int_ack    = 1'b0;
        eret_flush = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        ext_int_in = 6'd0; status_ie = 1'b0; status_exl = 1'b0; status_im = 8'd0;
        cause_ip_sw = 2'd0; cp0_addr = 7'd0; mtc0_data = 32'd0; mfc0_addr = 7'd0;
        quiet();
        #2 rst = 1'b1;
        #1;
        tests++;
        if (dut_vec() !== 41'd0) begin
            fails++;
            $display("FAIL reset_outputs: dut=%h want=0", dut_vec());
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (20) step();
        mfc0_re = 1'b1; mfc0_addr = A_COUNT;
        step();
        mfc0_re = 1'b0;
        tests++;
        if (mfc0_valid !== 1'b1 || mfc0_data !== 32'd10) begin
            fails++;
            $display("FAIL reset_count_read: valid=%b data=%0d want valid=1 data=10", mfc0_valid, mfc0_data);
        end
        tests++;
        if (cause_ti !== 1'b0 || int_req !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle_flags: ti=%b req=%b want 0 0", cause_ti, int_req);
        end
        step();
        tests++;
        if (mfc0_valid !== 1'b0 || mfc0_data !== 32'd10) begin
            fails++;
            $display("FAIL read_pulse_hold: valid=%b data=%0d want valid=0 data=10", mfc0_valid, mfc0_data);
        end
    endtask

    task automatic test_timer();
        int n;
        status_ie = 1'b1; status_exl = 1'b0; status_im = 8'h80;
        mtc0_we = 1'b1; cp0_addr = A_COUNT; mtc0_data = 32'd5;
        step();
        cp0_addr = A_COMPARE; mtc0_data = 32'd8;
        step();
        mtc0_we = 1'b0;
        n = 0;
        while (cause_ti !== 1'b1 && n < 20) begin
            tests++;
            if (dut_vec() !== mdl_vec()) begin
                fails++;
                $display("FAIL timer_run: dut=%h model=%h", dut_vec(), mdl_vec());
            end
            step();
            n++;
        end
        tests++;
        if (cause_ti !== 1'b1 || int_req !== 1'b0) begin
            fails++;
            $display("FAIL timer_ti_rise: ti=%b req=%b want 1 0", cause_ti, int_req);
        end
        tests++;
        if (dut_vec() !== mdl_vec()) begin
            fails++;
            $display("FAIL timer_match_state: dut=%h model=%h", dut_vec(), mdl_vec());
        end
        step();
        tests++;
        if (int_req !== 1'b1) begin
            fails++;
            $display("FAIL timer_int_req: req=%b want 1", int_req);
        end
        mtc0_we = 1'b1; cp0_addr = A_COMPARE; mtc0_data = 32'h0000_1000;
        step();
        mtc0_we = 1'b0;
        tests++;
        if (cause_ti !== 1'b0 || int_req !== 1'b1) begin
            fails++;
            $display("FAIL timer_ti_clear: ti=%b req=%b want 0 1", cause_ti, int_req);
        end
        step();
        tests++;
        if (int_req !== 1'b0 || dut_vec() !== mdl_vec()) begin
            fails++;
            $display("FAIL timer_withdraw: dut=%h model=%h", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_ext_int();
        status_ie = 1'b1; status_exl = 1'b0; status_im = 8'h10;
        ext_int_in = 6'b000100;
        step();
        tests++;
        if (cause_ip_hw[2] !== 1'b0) begin
            fails++;
            $display("FAIL ext_sync_1cyc: ip2=%b want 0", cause_ip_hw[2]);
        end
        step();
        tests++;
        if (cause_ip_hw !== 6'b000100 || int_req !== 1'b0) begin
            fails++;
            $display("FAIL ext_sync_2cyc: ip=%b req=%b want 000100 0", cause_ip_hw, int_req);
        end
        step();
        tests++;
        if (int_req !== 1'b1) begin
            fails++;
            $display("FAIL ext_int_req: req=%b want 1", int_req);
        end
        int_ack = 1'b1;
        step();
        int_ack = 1'b0; status_exl = 1'b1;
        tests++;
        if (int_req !== 1'b0 || dut_vec() !== mdl_vec()) begin
            fails++;
            $display("FAIL ext_ack_block: dut=%h model=%h", dut_vec(), mdl_vec());
        end
        step(); step();
        tests++;
        if (int_req !== 1'b0) begin
            fails++;
            $display("FAIL ext_block_hold: req=%b want 0", int_req);
        end
        eret_flush = 1'b1; status_exl = 1'b0;
        step();
        eret_flush = 1'b0;
        tests++;
        if (int_req !== 1'b0) begin
            fails++;
            $display("FAIL ext_eret_idle: req=%b want 0", int_req);
        end
        step();
        tests++;
        if (int_req !== 1'b1 || dut_vec() !== mdl_vec()) begin
            fails++;
            $display("FAIL ext_reassert: dut=%h model=%h", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_withdraw();
        ext_int_in = 6'd0;
        step(); step();
        tests++;
        if (int_req !== 1'b1 || cause_ip_hw[2] !== 1'b0) begin
            fails++;
            $display("FAIL wd_line_low: req=%b ip2=%b want 1 0", int_req, cause_ip_hw[2]);
        end
        step();
        tests++;
        if (int_req !== 1'b0) begin
            fails++;
            $display("FAIL wd_drop: req=%b want 0", int_req);
        end
        ext_int_in = 6'b000100;
        step(); step(); step();
        tests++;
        if (int_req !== 1'b1) begin
            fails++;
            $display("FAIL wd_rearm: req=%b want 1", int_req);
        end
        // withdrawal and ack in the same cycle: ack must win
        ext_int_in = 6'd0;
        step(); step();
        int_ack = 1'b1; status_exl = 1'b1;
        step();
        int_ack = 1'b0;
        tests++;
        if (int_req !== 1'b0 || dut_vec() !== mdl_vec()) begin
            fails++;
            $display("FAIL wd_ack_priority: dut=%h model=%h", dut_vec(), mdl_vec());
        end
        ext_int_in = 6'b000100;
        step(); step(); step();
        status_exl = 1'b0;
        step(); step();
        tests++;
        if (int_req !== 1'b0) begin
            fails++;
            $display("FAIL wd_in_block: req=%b want 0", int_req);
        end
        eret_flush = 1'b1;
        step();
        eret_flush = 1'b0;
        step();
        tests++;
        if (int_req !== 1'b1 || dut_vec() !== mdl_vec()) begin
            fails++;
            $display("FAIL wd_eret_req: dut=%h model=%h", dut_vec(), mdl_vec());
        end
        ext_int_in = 6'd0; status_ie = 1'b0;
        step(); step(); step();
    endtask

    task automatic test_wrap();
        status_ie = 1'b0;
        mtc0_we = 1'b1; cp0_addr = A_COMPARE; mtc0_data = 32'd0;
        step();
        for (int k = 0; k < 2 && m_tick; k++) step();
        cp0_addr = A_COUNT; mtc0_data = 32'hFFFF_FFFF;
        step();
        mtc0_we = 1'b0;
        tests++;
        if (cause_ti !== 1'b0) begin
            fails++;
            $display("FAIL wrap_pre: ti=%b want 0", cause_ti);
        end
        step();
        tests++;
        if (cause_ti !== 1'b1 || dut_vec() !== mdl_vec()) begin
            fails++;
            $display("FAIL wrap_ti_set: dut=%h model=%h", dut_vec(), mdl_vec());
        end
        mfc0_re = 1'b1; mfc0_addr = A_COUNT;
        step();
        mfc0_re = 1'b0;
        tests++;
        if (mfc0_data !== 32'd0) begin
            fails++;
            $display("FAIL wrap_count: data=%h want 0", mfc0_data);
        end
        // Compare write coinciding with the match clears TI
        mtc0_we = 1'b1; cp0_addr = A_COMPARE; mtc0_data = 32'd0;
        step();
        for (int k = 0; k < 2 && m_tick; k++) step();
        cp0_addr = A_COUNT; mtc0_data = 32'hFFFF_FFFF;
        step();
        cp0_addr = A_COMPARE; mtc0_data = 32'd0;
        step();
        mtc0_we = 1'b0;
        tests++;
        if (cause_ti !== 1'b0) begin
            fails++;
            $display("FAIL wrap_clear_wins: ti=%b want 0", cause_ti);
        end
        step(); step(); step();
        tests++;
        if (cause_ti !== 1'b0 || dut_vec() !== mdl_vec()) begin
            fails++;
            $display("FAIL wrap_after: dut=%h model=%h", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) ext_int_in = 6'($urandom);
            if ($urandom_range(0, 7) == 0) status_im = 8'($urandom);
            status_ie   = ($urandom_range(0, 3) != 0);
            status_exl  = ($urandom_range(0, 3) == 0);
            cause_ip_sw = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'd0;
            int_ack     = ($urandom_range(0, 3) == 0);
            eret_flush  = ($urandom_range(0, 5) == 0);
            mtc0_we     = ($urandom_range(0, 4) == 0);
            case ($urandom_range(0, 3))
                0: cp0_addr = A_COUNT;
                1: cp0_addr = A_COMPARE;
                2: cp0_addr = A_CAUSE;
                default: cp0_addr = 7'($urandom);
            endcase
            mtc0_data = ($urandom_range(0, 1) == 0) ? (m_count + 32'($urandom_range(0, 6)))
                                                    : $urandom;
            mfc0_re = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: mfc0_addr = A_COUNT;
                1: mfc0_addr = A_COMPARE;
                2: mfc0_addr = A_CAUSE;
                default: mfc0_addr = 7'($urandom);
            endcase
            step();
            tests++;
            if (dut_vec() !== mdl_vec()) begin
                fails++;
                $display("FAIL random_cycle%0d: dut=%h model=%h", i, dut_vec(), mdl_vec());
            end
        end
        quiet();
    endtask

    task automatic test_reset_async();
        int n;
        cause_ip_sw = 2'd0;
        eret_flush = 1'b1;
        step();
        eret_flush = 1'b0;
        status_ie = 1'b1; status_exl = 1'b0; status_im = 8'h10; ext_int_in = 6'b000100;
        n = 0;
        while (int_req !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        tests++;
        if (int_req !== 1'b1) begin
            fails++;
            $display("FAIL arst_setup: req=%b want 1", int_req);
        end
        #3 rst = 1'b1;
        #1;
        tests++;
        if (int_req !== 1'b0 || dut_vec() !== mdl_vec()) begin
            fails++;
            $display("FAIL arst_async_drop: dut=%h model=%h", dut_vec(), mdl_vec());
        end
        ext_int_in = 6'd0; status_ie = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        mfc0_re = 1'b1; mfc0_addr = A_COUNT;
        step();
        tests++;
        if (mfc0_data !== 32'd0) begin
            fails++;
            $display("FAIL arst_count: data=%h want 0", mfc0_data);
        end
        mfc0_addr = A_COMPARE;
        step();
        mfc0_re = 1'b0;
        tests++;
        if (mfc0_data !== 32'hFFFF_FFFF || mfc0_valid !== 1'b1) begin
            fails++;
            $display("FAIL arst_compare: data=%h valid=%b want FFFFFFFF 1", mfc0_data, mfc0_valid);
        end
    endtask

    initial begin
        test_reset();
        test_timer();
        test_ext_int();
        test_withdraw();
        test_wrap();
        test_back_to_back();
        test_reset_async();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
        $fatal(1);
    end

endmodule
